// File: rtl/mux_select_scanner_if.sv
// Handshake and mux-side signals of the select scanner.
// The controller/mux side takes master; the scanner takes slave.
interface mux_select_scanner_if;
    logic       start;
    logic       mux_out;
    logic       s1;
    logic       s0;
    logic       busy;
    logic       done;
    logic [3:0] sample;

    modport master (
        output start,
        output mux_out,
        input  s1,
        input  s0,
        input  busy,
        input  done,
        input  sample
    );

    modport slave (
        input  start,
        input  mux_out,
        output s1,
        output s0,
        output busy,
        output done,
        output sample
    );
endinterface

// File: rtl/mux_select_scanner.sv
// Steps a 4:1 mux select through 00..11, holding each for
// SETTLE_CYCLES+1 cycles, and packs the outputs into a word.
module mux_select_scanner #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mux_select_scanner_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    // Only the low 4 bits are meaningful; legal range is 0..15.
    localparam logic [3:0] LP_RELOAD = 4'(SETTLE_CYCLES);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] r_sample;
    logic [3:0] w_sample_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       r_done;
    logic       w_done_nxt;

    // State, select, counter and outputs are all registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sel    <= 2'b00;
            r_cnt    <= 4'd0;
            r_sample <= 4'b0000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sample <= w_sample_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state: start only accepted in IDLE; each select is held
    // until the counter drains, then the mux output is captured.
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_cnt_nxt    = r_cnt;
        w_sample_nxt = r_sample;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_sel_nxt = 2'b00;
                if (bus.start) begin
                    w_state_nxt  = S_SCAN;
                    w_busy_nxt   = 1'b1;
                    w_sample_nxt = 4'b0000;
                    w_cnt_nxt    = LP_RELOAD;
                end
            end
            S_SCAN: begin
                w_busy_nxt = 1'b1;
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_sample_nxt[r_sel] = bus.mux_out;
                    if (r_sel != 2'b11) begin
                        w_sel_nxt = r_sel + 2'd1;
                        w_cnt_nxt = LP_RELOAD;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_sel_nxt   = 2'b00;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sel_nxt   = 2'b00;
            end
        endcase
    end

    assign bus.s1     = r_sel[1];
    assign bus.s0     = r_sel[0];
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.sample = r_sample;
endmodule
